mac_rx_frame_sink: RTL
======================

# mac_rx_frame_sink

Synthesizable consumer of the MAC receive stream: 32-bit AXI-stream beats, byte 0 in `tdata[31:24]`, `tkeep` MSB-first, frame length on `tuser`. The block stores one frame at a time in an internal word RAM. It validates the frame and presents it to the packet-processing logic through a byte-addressed read port with a frame_valid/frame_ack handshake. It sits directly behind the MAC receive interface and is the RX-side counterpart of the MAC emulator's frame source.

## Interface
- `ADDR_WIDTH`, 12: RAM word-address width; capacity 4·2^ADDR_WIDTH bytes (16384 at default).
- `clk` in 1: sole clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mac_rx_tdata` in 32: beat data, byte 0 in [31:24].
- `mac_rx_tkeep` in 4: byte enables, MSB-first.
- `mac_rx_tuser` in 16: declared frame length in bytes, sampled on the first beat.
- `mac_rx_tvalid` in 1: beat valid.
- `mac_rx_tlast` in 1: last beat of frame.
- `mac_rx_tready` out 1: registered ready.
- `rd_addr` in ADDR_WIDTH+2: byte address into the held frame.
- `rd_data` out 8: byte at `rd_addr`, 1-cycle latency.
- `frame_valid` out 1: a complete, good frame is held.
- `frame_len` out 16: byte length of the held frame.
- `frame_ack` in 1: release the held frame.
- `stat_drop_cnt` out 16: count of dropped frames, saturating.

## Operation
- States: RECV (tready=1), DROP (tready=1, discard), HOLD (tready=0, frame_valid=1).
- A beat is accepted when tvalid & tready.
- RECV:
  - Each accepted beat is written to `ram[wr_ptr]`; `wr_ptr` increments.
  - `byte_cnt` += popcount(tkeep).
  - `tuser` is latched on the first beat of the frame (wr_ptr==0); later `tuser` values are ignored.
- Legal tkeep:
  - Non-last beat: 1111 only.
  - Last beat: 1111, 1110, 1100 or 1000.
  - Any other value, including 0000, marks the frame bad.
- Overflow: a beat accepted with `wr_ptr` == 2^ADDR_WIDTH (RAM full) marks the frame bad.
- Bad frame detected on a non-last beat → DROP. DROP discards beats until a tlast beat, then the drop is committed.
- Bad frame detected on the tlast beat → drop committed immediately; no DROP state.
- Drop commit: `stat_drop_cnt` += 1 (saturates at 0xFFFF); `wr_ptr`, `byte_cnt` cleared; state → RECV.
- Good tlast beat → HOLD; `frame_len` ← final `byte_cnt`.
- HOLD:
  - `frame_ack`=1 → frame_valid 0, state → RECV, `wr_ptr`/`byte_cnt` cleared.
  - `frame_ack` while not in HOLD is ignored.
- Read port: registered RAM read. `rd_data` = `ram[rd_addr[ADDR_WIDTH+1:2]]`, byte lane selected by `rd_addr[1:0]` (0 → [31:24]). Reads are legal in any state; contents are defined only in HOLD for `rd_addr` < `frame_len`.
- Arithmetic: `byte_cnt` is 17 bits internally. A count exceeding 0xFFFF is treated as overflow (bad frame).

## Timing
- Reset values:
  - `mac_rx_tready`=0; becomes 1 on the first cycle after `rst` deasserts.
  - `frame_valid`=0, `frame_len`=0, `stat_drop_cnt`=0, `rd_data`=0.
  - State RECV, `wr_ptr`=0.
- Throughput: one beat per cycle in RECV/DROP; no bubbles between frames after a drop.
- tready is registered:
  - It falls in the cycle after a good tlast beat is accepted; no beat is accepted in that cycle.
  - It rises in the cycle after `frame_ack` is sampled in HOLD.
- `frame_valid` and `frame_len` are valid the cycle after the good tlast beat.
- `rd_data` is valid one cycle after `rd_addr` is presented.
- Reset mid-frame: the partial frame is discarded silently; `stat_drop_cnt` is cleared, not incremented.

## Configuration
- `MAC_RX_FRAME_SINK_LEN_CHECK_EN` defined:
  - At a good tlast, `byte_cnt` != latched `tuser` → the frame is dropped and counted.
- Not defined:
  - `tuser` is ignored; `frame_len` = counted bytes.
  - All other checks (tkeep legality, overflow) remain.

## Test plan
- 64-byte frame, `tuser`=64, 16 beats of tkeep=1111 → `frame_valid`=1 one cycle after tlast, `frame_len`=64; `rd_addr`=0 returns byte 0 two cycles later; `stat_drop_cnt`=0.
- 61-byte frame, last beat tkeep=1000 → `frame_len`=61; `rd_addr`=60 returns `tdata[31:24]` of the last beat; `tready` stays 0 until `frame_ack`.
- 96-byte frame with `tuser`=100 → with macro: no `frame_valid`, `stat_drop_cnt`=1; without macro: `frame_valid`, `frame_len`=96.
- ADDR_WIDTH=4, 80-byte frame → DROP after beat 16, `stat_drop_cnt`=1; a following 32-byte frame is captured with `frame_len`=32.
- Second frame offered while in HOLD → `tready`=0 and no beats consumed; `frame_ack` pulse → `tready`=1 next cycle; frame 2 captured intact.
- `rst` pulsed after 5 beats of a 64-byte frame → `tready`=0 during reset, `stat_drop_cnt`=0; a new 64-byte frame is then received with `frame_len`=64.

Source files
------------

// File: rtl/mac_rx_frame_sink_if.sv
// MAC receive AXI-stream bundle: 32-bit beats, byte 0 in tdata[31:24], MSB-first tkeep,
// frame length on tuser. The master is the MAC side; the slave is the frame sink.
interface mac_rx_frame_sink_if;
  logic [31:0] mac_rx_tdata;
  logic [3:0]  mac_rx_tkeep;
  logic [15:0] mac_rx_tuser;
  logic        mac_rx_tvalid;
  logic        mac_rx_tlast;
  logic        mac_rx_tready;

  modport master (
    output mac_rx_tdata, mac_rx_tkeep, mac_rx_tuser, mac_rx_tvalid, mac_rx_tlast,
    input  mac_rx_tready
  );

  modport slave (
    input  mac_rx_tdata, mac_rx_tkeep, mac_rx_tuser, mac_rx_tvalid, mac_rx_tlast,
    output mac_rx_tready
  );
endinterface

// File: rtl/mac_rx_frame_sink.sv
// Single-frame receive buffer: validates one MAC frame, holds it in a word RAM for byte reads.
// Optional build macro MAC_RX_FRAME_SINK_LEN_CHECK_EN drops frames whose count differs from tuser.
module mac_rx_frame_sink #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  mac_rx_frame_sink_if.slave    rx,
  input  logic [ADDR_WIDTH+1:0] rd_addr,
  output logic [7:0]            rd_data,
  output logic                  frame_valid,
  output logic [15:0]           frame_len,
  input  logic                  frame_ack,
  output logic [15:0]           stat_drop_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {S_RECV, S_DROP, S_HOLD} state_t;

  function automatic logic [2:0] keep_bytes(input logic [3:0] k);
    return 3'(k[3]) + 3'(k[2]) + 3'(k[1]) + 3'(k[0]);
  endfunction

  function automatic logic keep_legal(input logic [3:0] k, input logic last);
    if (!last) return (k == 4'b1111);
    return (k == 4'b1111) || (k == 4'b1110) || (k == 4'b1100) || (k == 4'b1000);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] lane_sel(input logic [31:0] w, input logic [1:0] lane);
    case (lane)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [16:0]           byte_cnt_q, byte_cnt_d;
  logic [15:0]           tuser_q, tuser_d;
  logic [15:0]           frame_len_q, frame_len_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;
  logic                  tready_q, tready_d;
  logic [7:0]            rd_data_q, rd_data_d;

  logic [31:0]           ram [DEPTH];
  logic                  ram_we;
  logic                  accept;
  logic                  beat_bad;
  logic                  len_bad;
  logic                  commit_drop;
  logic [16:0]           byte_cnt_nxt;
  logic [15:0]           tuser_eff;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    byte_cnt_d   = byte_cnt_q;
    tuser_d      = tuser_q;
    frame_len_d  = frame_len_q;
    drop_cnt_d   = drop_cnt_q;
    ram_we       = 1'b0;
    commit_drop  = 1'b0;
    accept       = rx.mac_rx_tvalid & tready_q;
    byte_cnt_nxt = byte_cnt_q + 17'(keep_bytes(rx.mac_rx_tkeep));
    // A full RAM or a count past 16 bits is an overflow, same as an illegal tkeep.
    beat_bad     = !keep_legal(rx.mac_rx_tkeep, rx.mac_rx_tlast)
                   || wr_ptr_q[ADDR_WIDTH] || byte_cnt_nxt[16];
    // A single-beat frame has not latched tuser yet, so compare against the live value.
    tuser_eff    = (wr_ptr_q == '0) ? rx.mac_rx_tuser : tuser_q;
`ifdef MAC_RX_FRAME_SINK_LEN_CHECK_EN
    len_bad      = (byte_cnt_nxt[15:0] != tuser_eff);
`else
    len_bad      = 1'b0;
`endif

    case (state_q)
      S_RECV: begin
        if (accept) begin
          if (beat_bad) begin
            if (rx.mac_rx_tlast) commit_drop = 1'b1;
            else                 state_d     = S_DROP;
          end else begin
            ram_we     = 1'b1;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            byte_cnt_d = byte_cnt_nxt;
            if (wr_ptr_q == '0) tuser_d = rx.mac_rx_tuser;
            if (rx.mac_rx_tlast) begin
              if (len_bad) begin
                commit_drop = 1'b1;
              end else begin
                state_d     = S_HOLD;
                frame_len_d = byte_cnt_nxt[15:0];
              end
            end
          end
        end
      end
      S_DROP: begin
        if (accept && rx.mac_rx_tlast) commit_drop = 1'b1;
      end
      S_HOLD: begin
        if (frame_ack) begin
          state_d    = S_RECV;
          wr_ptr_d   = '0;
          byte_cnt_d = '0;
        end
      end
      default: state_d = S_RECV;
    endcase

    if (commit_drop) begin
      drop_cnt_d = sat_inc16(drop_cnt_q);
      wr_ptr_d   = '0;
      byte_cnt_d = '0;
      state_d    = S_RECV;
    end

    tready_d  = (state_d != S_HOLD);
    rd_data_d = lane_sel(ram[rd_addr[ADDR_WIDTH+1:2]], rd_addr[1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RECV;
      wr_ptr_q    <= '0;
      byte_cnt_q  <= '0;
      frame_len_q <= '0;
      drop_cnt_q  <= '0;
      tready_q    <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      frame_len_q <= frame_len_d;
      drop_cnt_q  <= drop_cnt_d;
      tready_q    <= tready_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Storage: frame words and the latched length carry no reset.
  always_ff @(posedge clk) begin
    tuser_q <= tuser_d;
    if (ram_we) ram[wr_ptr_q[ADDR_WIDTH-1:0]] <= rx.mac_rx_tdata;
  end

  assign rx.mac_rx_tready = tready_q;
  assign frame_valid      = (state_q == S_HOLD);
  assign frame_len        = frame_len_q;
  assign stat_drop_cnt    = drop_cnt_q;
  assign rd_data          = rd_data_q;

endmodule
